// File: rtl/vn_alloc_pkg.sv
// vn_alloc_pkg
//   Shared definitions for the row-to-virtual-neuron allocator.
//   - state_e : allocator FSM encoding (IDLE, FILL, FLUSH2)
//   - vn_pad  : identity VN-ID vector (slot k carries VN-ID k). Pad slots
//               therefore never share an ID with a neighbour.
package vn_alloc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_FLUSH2 = 2'd2
    } state_e;

    // Upper bound on NUM_PES*LOG2_PES supported by vn_pad.
    localparam int PAD_MAX_W = 256;

    // Identity VN-ID vector: field k (LOG2_PES bits wide) holds the value k.
    function automatic logic [PAD_MAX_W-1:0] vn_pad(input int num_pes, input int log2_pes);
        logic [PAD_MAX_W-1:0] v;
        v = '0;
        for (int k = 0; k < num_pes; k++) begin
            for (int b = 0; b < log2_pes; b++) begin
                v[k*log2_pes + b] = k[b];
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/vn_alloc_if.sv
// vn_alloc_if
//   Row-stream input and packed-cycle output bundle of vn_alloc.
//   Inputs : i_row_len, i_row_valid, i_row_last, i_stationary
//   Outputs: o_row_ready, o_vn, o_pe_mask, o_stationary, o_data_valid,
//            o_first_row, o_err
//   master modport = row source / output sink, slave modport = vn_alloc.
interface vn_alloc_if #(
    parameter int NUM_PES  = 4,
    parameter int LOG2_PES = 2,
    parameter int ROW_W    = 16
);
    logic [LOG2_PES:0]          i_row_len;
    logic                       i_row_valid;
    logic                       i_row_last;
    logic                       o_row_ready;
    logic                       i_stationary;
    logic [NUM_PES*LOG2_PES-1:0] o_vn;
    logic [NUM_PES-1:0]         o_pe_mask;
    logic                       o_stationary;
    logic                       o_data_valid;
    logic [ROW_W-1:0]           o_first_row;
    logic                       o_err;

    modport master (
        output i_row_len, i_row_valid, i_row_last, i_stationary,
        input  o_row_ready, o_vn, o_pe_mask, o_stationary, o_data_valid,
               o_first_row, o_err
    );

    modport slave (
        input  i_row_len, i_row_valid, i_row_last, i_stationary,
        output o_row_ready, o_vn, o_pe_mask, o_stationary, o_data_valid,
               o_first_row, o_err
    );
endinterface

// File: rtl/vn_alloc_slot_fill.sv
// vn_slot_fill
//   Combinational slot writer. Given the current fill level and a row length,
//   stamps slots fill..fill+len-1 with VN-ID = fill and sets their mask bits;
//   all other slots pass through unchanged.
//   Ports: fill_i, len_i, vn_i, mask_i -> vn_o, mask_o
module vn_slot_fill #(
    parameter int NUM_PES  = 4,
    parameter int LOG2_PES = 2
) (
    input  logic [LOG2_PES:0]           fill_i,
    input  logic [LOG2_PES:0]           len_i,
    input  logic [NUM_PES*LOG2_PES-1:0] vn_i,
    input  logic [NUM_PES-1:0]          mask_i,
    output logic [NUM_PES*LOG2_PES-1:0] vn_o,
    output logic [NUM_PES-1:0]          mask_o
);
    always_comb begin
        vn_o   = vn_i;
        mask_o = mask_i;
        for (int k = 0; k < NUM_PES; k++) begin
            if ((k >= int'(fill_i)) && (k < int'(fill_i) + int'(len_i))) begin
                // The row's VN-ID is its starting slot, unique within the cycle.
                vn_o[k*LOG2_PES +: LOG2_PES] = fill_i[LOG2_PES-1:0];
                mask_o[k]                    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vn_alloc.sv
// vn_alloc
//   Packs whole output rows (by nonzero count) into NUM_PES-slot cycles for
//   the FAN reduction controller. A row is never split across cycles.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     bus       : vn_alloc_if slave (row stream in, packed cycle out)
//   Outputs are registered: o_data_valid rises the cycle after the accepting
//   edge. An overflow row that also completes its own buffer (last or full)
//   produces two strobes on consecutive cycles; rows are held off for one
//   cycle (FLUSH2) while the second one goes out.
module vn_alloc
    import vn_alloc_pkg::*;
#(
    parameter int NUM_PES  = 4,
    parameter int LOG2_PES = 2,
    parameter int ROW_W    = 16
) (
    input logic      clk,
    input logic      rst,
    vn_alloc_if.slave bus
);
    localparam int FW = LOG2_PES + 1;
    localparam int VW = NUM_PES * LOG2_PES;
    localparam logic [VW-1:0] PAD   = VW'(vn_pad(NUM_PES, LOG2_PES));
    localparam logic [FW-1:0] PES_F = FW'(NUM_PES);
    localparam logic [FW:0]   PES_S = (FW+1)'(NUM_PES);

    state_e               state_q, state_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
    logic                 err_q, err_d;
    logic                 dv_q, dv_d;
    logic [VW-1:0]        vn_out_q, vn_out_d;
    logic [NUM_PES-1:0]   mask_out_q, mask_out_d;
    logic                 stat_out_q, stat_out_d;
    logic [ROW_W-1:0]     first_out_q, first_out_d;
    // Packing buffer payload; only meaningful while fill_q > 0.
    logic [VW-1:0]        vn_buf_q, vn_buf_d;
    logic [NUM_PES-1:0]   mask_buf_q, mask_buf_d;
    logic                 stat_buf_q, stat_buf_d;
    logic [ROW_W-1:0]     first_buf_q, first_buf_d;

    logic [FW-1:0]        len;
    logic [FW:0]          sum;
    logic                 fresh, bad, place, ovf, ready, acc;
    logic [FW-1:0]        base_fill;
    logic [VW-1:0]        base_vn, new_vn;
    logic [NUM_PES-1:0]   base_mask, new_mask;
    logic                 emit_old, emit_new;

    assign len   = bus.i_row_len;
    assign fresh = (fill_q == '0);
    assign sum   = {1'b0, fill_q} + {1'b0, len};
    assign bad   = (len > PES_F);
    assign place = (len != '0) && !bad;
    assign ovf   = place && (sum > PES_S);
    assign ready = (state_q != ST_FLUSH2);
    assign acc   = bus.i_row_valid && ready;

    // An overflowing row seeds a brand-new buffer at slot 0; otherwise the
    // row is appended to the current buffer (pad vector when empty).
    assign base_fill = ovf ? '0 : fill_q;
    assign base_vn   = (ovf || fresh) ? PAD : vn_buf_q;
    assign base_mask = (ovf || fresh) ? '0  : mask_buf_q;

    vn_slot_fill #(
        .NUM_PES  (NUM_PES),
        .LOG2_PES (LOG2_PES)
    ) u_slot_fill (
        .fill_i (base_fill),
        .len_i  (len),
        .vn_i   (base_vn),
        .mask_i (base_mask),
        .vn_o   (new_vn),
        .mask_o (new_mask)
    );

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        row_cnt_d   = row_cnt_q;
        err_d       = err_q;
        dv_d        = 1'b0;
        vn_out_d    = vn_out_q;
        mask_out_d  = mask_out_q;
        stat_out_d  = stat_out_q;
        first_out_d = first_out_q;
        vn_buf_d    = vn_buf_q;
        mask_buf_d  = mask_buf_q;
        stat_buf_d  = stat_buf_q;
        first_buf_d = first_buf_q;
        emit_old    = 1'b0;
        emit_new    = 1'b0;

        case (state_q)
            ST_FLUSH2: begin
                // Second strobe: the buffer seeded by the overflow row.
                emit_old = 1'b1;
                fill_d   = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                if (acc) begin
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                    if (bad) begin
                        err_d = 1'b1;
                    end
                    if (place && !ovf) begin
                        if ((sum == PES_S) || bus.i_row_last) begin
                            emit_new = 1'b1;
                            fill_d   = '0;
                            state_d  = ST_IDLE;
                        end else begin
                            vn_buf_d   = new_vn;
                            mask_buf_d = new_mask;
                            fill_d     = sum[FW-1:0];
                            state_d    = ST_FILL;
                            if (fresh) begin
                                first_buf_d = row_cnt_q;
                                stat_buf_d  = bus.i_stationary;
                            end
                        end
                    end else if (ovf) begin
                        emit_old    = 1'b1;
                        vn_buf_d    = new_vn;
                        mask_buf_d  = new_mask;
                        fill_d      = len;
                        first_buf_d = row_cnt_q;
                        stat_buf_d  = bus.i_stationary;
                        state_d     = ((len == PES_F) || bus.i_row_last) ? ST_FLUSH2 : ST_FILL;
                    end else if (bus.i_row_last && !fresh) begin
                        // Empty or dropped last row still closes a partial buffer.
                        emit_old = 1'b1;
                        fill_d   = '0;
                        state_d  = ST_IDLE;
                    end
                end
            end
        endcase

        if (emit_old) begin
            dv_d        = 1'b1;
            vn_out_d    = vn_buf_q;
            mask_out_d  = mask_buf_q;
            stat_out_d  = stat_buf_q;
            first_out_d = first_buf_q;
        end else if (emit_new) begin
            dv_d        = 1'b1;
            vn_out_d    = new_vn;
            mask_out_d  = new_mask;
            stat_out_d  = fresh ? bus.i_stationary : stat_buf_q;
            first_out_d = fresh ? row_cnt_q : first_buf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fill_q      <= '0;
            row_cnt_q   <= '0;
            err_q       <= 1'b0;
            dv_q        <= 1'b0;
            vn_out_q    <= '0;
            mask_out_q  <= '0;
            stat_out_q  <= 1'b0;
            first_out_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            row_cnt_q   <= row_cnt_d;
            err_q       <= err_d;
            dv_q        <= dv_d;
            vn_out_q    <= vn_out_d;
            mask_out_q  <= mask_out_d;
            stat_out_q  <= stat_out_d;
            first_out_q <= first_out_d;
        end
    end

    always_ff @(posedge clk) begin
        vn_buf_q    <= vn_buf_d;
        mask_buf_q  <= mask_buf_d;
        stat_buf_q  <= stat_buf_d;
        first_buf_q <= first_buf_d;
    end

    assign bus.o_row_ready  = ready;
    assign bus.o_vn         = vn_out_q;
    assign bus.o_pe_mask    = mask_out_q;
    assign bus.o_stationary = stat_out_q;
    assign bus.o_data_valid = dv_q;
    assign bus.o_first_row  = first_out_q;
    assign bus.o_err        = err_q;

endmodule

// File: tb/tb_vn_alloc.sv
// tb_vn_alloc
//   Directed bench for vn_alloc. A row-list model tracks which row owns each
//   slot and predicts every strobe; a negedge monitor compares the DUT each
//   cycle. Literal expectations after each scenario pin the model.
module tb_vn_alloc;
    localparam int N  = 4;
    localparam int LG = 2;
    localparam int RW = 16;
    localparam int VW = N * LG;

    typedef struct packed {
        logic          v;
        logic [VW-1:0] vn;
        logic [N-1:0]  mask;
        logic          st;
        logic [RW-1:0] first;
    } emit_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vn_alloc_if #(.NUM_PES(N), .LOG2_PES(LG), .ROW_W(RW)) bus();

    vn_alloc #(.NUM_PES(N), .LOG2_PES(LG), .ROW_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int    m_owner[N];
    int    m_fill = 0;
    int    m_rowcnt = 0;
    int    m_first = 0;
    bit    m_st = 1'b0;
    bit    m_err = 1'b0;
    bit    m_flush2 = 1'b0;
    emit_t exp_now = '0;
    emit_t exp_later = '0;
    emit_t obs[$];

    function automatic emit_t m_snap();
        emit_t e;
        e.v = 1'b1;
        e.st = m_st;
        e.first = RW'(m_first);
        e.mask = '0;
        e.vn = '0;
        for (int k = 0; k < N; k++) begin
            if (m_owner[k] >= 0) begin
                e.vn[k*LG +: LG] = LG'(m_owner[k]);
                e.mask[k] = 1'b1;
            end else begin
                e.vn[k*LG +: LG] = LG'(k);
            end
        end
        return e;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < N; k++) m_owner[k] = -1;
        m_fill = 0;
    endtask

    task automatic m_place(input int len, input int rc, input bit st);
        if (m_fill == 0) begin
            m_first = rc;
            m_st = st;
        end
        for (int j = 0; j < len; j++) m_owner[m_fill + j] = m_fill;
        m_fill += len;
    endtask

    task automatic m_accept(input int len, input bit last, input bit st);
        int rc;
        rc = m_rowcnt;
        m_rowcnt = (m_rowcnt + 1) % (1 << RW);
        if (len > N || len == 0) begin
            if (len > N) m_err = 1'b1;
            if (last && m_fill > 0) begin
                exp_now = m_snap();
                m_clear();
            end
        end else if (m_fill + len > N) begin
            exp_now = m_snap();
            m_clear();
            m_place(len, rc, st);
            if (len == N || last) begin
                exp_later = m_snap();
                m_clear();
                m_flush2 = 1'b1;
            end
        end else begin
            m_place(len, rc, st);
            if (m_fill == N || last) begin
                exp_now = m_snap();
                m_clear();
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_dv", bus.o_data_valid, 0);
            chk("rst_vn", bus.o_vn, 0);
            chk("rst_mask", bus.o_pe_mask, 0);
            chk("rst_first", bus.o_first_row, 0);
            chk("rst_err", bus.o_err, 0);
            chk("rst_stat", bus.o_stationary, 0);
            m_clear();
            m_rowcnt = 0;
            m_err = 1'b0;
            m_flush2 = 1'b0;
            exp_now = '0;
            exp_later = '0;
        end else begin
            chk("dv", bus.o_data_valid, exp_now.v);
            if (exp_now.v && bus.o_data_valid) begin
                chk("vn", bus.o_vn, exp_now.vn);
                chk("mask", bus.o_pe_mask, exp_now.mask);
                chk("first_row", bus.o_first_row, exp_now.first);
                chk("stationary", bus.o_stationary, exp_now.st);
            end
            if (bus.o_data_valid) begin
                obs.push_back({1'b1, bus.o_vn, bus.o_pe_mask, bus.o_stationary, bus.o_first_row});
            end
            exp_now = exp_later;
            exp_later = '0;
            chk("ready", bus.o_row_ready, !m_flush2);
            chk("err", bus.o_err, m_err);
            if (m_flush2) begin
                m_flush2 = 1'b0;
            end else if (bus.i_row_valid) begin
                m_accept(int'(bus.i_row_len), bus.i_row_last, bus.i_stationary);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int len, input bit last, input bit st);
        int tries;
        tries = 0;
        bus.i_row_len = (LG+1)'(len);
        bus.i_row_last = last;
        bus.i_stationary = st;
        bus.i_row_valid = 1'b1;
        @(negedge clk);
        while (!bus.o_row_ready && tries < 8) begin
            @(negedge clk);
            tries++;
        end
        if (!bus.o_row_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: ready stayed %0d, required 1", bus.o_row_ready);
        end
        @(posedge clk);
        #1;
        bus.i_row_valid = 1'b0;
        bus.i_row_last = 1'b0;
        bus.i_stationary = 1'b0;
        bus.i_row_len = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic check_obs(input string nm, input logic [VW-1:0] vn, input logic [N-1:0] mask,
                             input logic [RW-1:0] first, input logic st);
        emit_t e;
        if (obs.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_strobe: got no strobe, required one", nm);
        end else begin
            e = obs.pop_front();
            chk({nm, "_vn"}, e.vn, vn);
            chk({nm, "_mask"}, e.mask, mask);
            chk({nm, "_first"}, e.first, first);
            chk({nm, "_stat"}, e.st, st);
        end
    endtask

    task automatic check_none(input string nm);
        chk({nm, "_extra_strobes"}, obs.size(), 0);
        obs.delete();
    endtask

    initial begin
        bus.i_row_len = '0;
        bus.i_row_valid = 1'b0;
        bus.i_row_last = 1'b0;
        bus.i_stationary = 1'b0;
        #1;
        do_reset();
        idle(2);

        // lens 2,2 (last)
        send(2, 1'b0, 1'b0); send(2, 1'b1, 1'b0); idle(3);
        check_obs("t1", 8'hA0, 4'hF, 16'd0, 1'b0); check_none("t1");
        // lens 1,3 -> buffer full
        send(1, 1'b0, 1'b0); send(3, 1'b0, 1'b0); idle(3);
        check_obs("t2", 8'h54, 4'hF, 16'd2, 1'b0); check_none("t2");
        // lens 3, 2 (last) -> overflow + flush
        send(3, 1'b0, 1'b0); send(2, 1'b1, 1'b0); idle(4);
        check_obs("t3a", 8'hC0, 4'h7, 16'd4, 1'b0);
        check_obs("t3b", 8'hE0, 4'h3, 16'd5, 1'b0); check_none("t3");
        chk("t3_err", bus.o_err, 0);

        do_reset();
        // len 5 dropped, then len 4 last
        send(5, 1'b0, 1'b0); idle(2);
        chk("t4_err", bus.o_err, 1);
        check_none("t4_drop");
        send(4, 1'b1, 1'b0); idle(3);
        check_obs("t4", 8'h00, 4'hF, 16'd1, 1'b0); check_none("t4");
        // lens 1 (stationary), 0 (last)
        send(1, 1'b0, 1'b1); send(0, 1'b1, 1'b0); idle(3);
        check_obs("t5", 8'hE4, 4'h1, 16'd2, 1'b1); check_none("t5");
        chk("t5_err_sticky", bus.o_err, 1);
        // len 1 then len 4: overflow with a full new buffer; next row stalls
        send(1, 1'b0, 1'b0); send(4, 1'b0, 1'b1);
        send(3, 1'b0, 1'b0); send(2, 1'b0, 1'b0); send(2, 1'b1, 1'b0); idle(4);
        check_obs("t7a", 8'hE4, 4'h1, 16'd4, 1'b0);
        check_obs("t7b", 8'h00, 4'hF, 16'd5, 1'b1);
        check_obs("t8a", 8'hC0, 4'h7, 16'd6, 1'b0);
        check_obs("t8b", 8'hA0, 4'hF, 16'd7, 1'b0); check_none("t8");
        // empty last row on an empty buffer: nothing
        send(0, 1'b1, 1'b0); idle(3);
        check_none("t9");

        // reset mid-batch discards the partial buffer
        send(2, 1'b0, 1'b0);
        do_reset();
        chk("t6_err_cleared", bus.o_err, 0);
        send(4, 1'b0, 1'b0); idle(3);
        check_obs("t6", 8'h00, 4'hF, 16'd0, 1'b0); check_none("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
